nco_voice_allocator: RTL and testbench

Polyphonic voice controller for a bank of NCO voices. It accepts note-on/note-off events over a valid/ready handshake, allocates each note to a free voice, and steals a voice round-robin when none is free. For the chosen voice it sequences the per-voice `loadF`, `loadA` and `key_on` controls, and it drives a shared frequency/amplitude bus that feeds every voice's `F_in` and `A_in`. The block sits between the note-event source (keyboard/MIDI decoder) and the NCO array.

---
 rtl/nco_voice_allocator.sv | 150 +++++++++++++++
 tb/tb_nco_voice_allocator.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_voice_allocator.sv
// Polyphonic note-event allocator for a bank of NCO voices: assigns note-on/off
// events to voices (free, retrigger or round-robin steal) and sequences per-voice loads.
module nco_voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int FW         = 24,
    parameter int AW         = 16,
    parameter int NOTE_W     = 7
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic                              evt_valid,
    output logic                              evt_ready,
    input  logic                              evt_on,
    input  logic [NOTE_W-1:0]                 evt_note,
    input  logic [FW-1:0]                     evt_freq,
    input  logic [AW-1:0]                     evt_amp,
    input  logic                              panic,
    output logic [FW-1:0]                     F_bus,
    output logic [AW-1:0]                     A_bus,
    output logic [NUM_VOICES-1:0]             voice_loadF,
    output logic [NUM_VOICES-1:0]             voice_loadA,
    output logic [NUM_VOICES-1:0]             voice_key_on,
    output logic [$clog2(NUM_VOICES+1)-1:0]   active_count,
    output logic                              steal_pulse,
    output logic                              miss_pulse
);

    localparam int VW = $clog2(NUM_VOICES);
    localparam int CW = $clog2(NUM_VOICES + 1);

    typedef enum logic [2:0] {IDLE, SEARCH, KILL, LOAD, OFF} state_t;

    state_t              state;
    logic                hold_on;
    logic [NOTE_W-1:0]   hold_note;
    logic [FW-1:0]       hold_freq;
    logic [AW-1:0]       hold_amp;
    logic [VW-1:0]       tgt;
    logic [VW-1:0]       steal_ptr;
    logic [NOTE_W-1:0]   tag_note [NUM_VOICES];

    logic                hit;
    logic [VW-1:0]       hit_idx;
    logic                free;
    logic [VW-1:0]       free_idx;

    // A tag is valid exactly when its voice is keyed on, so key_on doubles as the valid bit.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!hit && voice_key_on[i] && (tag_note[i] == hold_note)) begin
                hit     = 1'b1;
                hit_idx = VW'(i);
            end
            if (!free && !voice_key_on[i]) begin
                free     = 1'b1;
                free_idx = VW'(i);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            hold_on      <= 1'b0;
            hold_note    <= '0;
            hold_freq    <= '0;
            hold_amp     <= '0;
            tgt          <= '0;
            steal_ptr    <= '0;
            F_bus        <= '0;
            A_bus        <= '0;
            voice_key_on <= '0;
            for (int i = 0; i < NUM_VOICES; i++) tag_note[i] <= '0;
        end else if (panic) begin
            state        <= IDLE;
            voice_key_on <= '0;
            for (int i = 0; i < NUM_VOICES; i++) tag_note[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (evt_valid) begin
                        hold_on   <= evt_on;
                        hold_note <= evt_note;
                        hold_freq <= evt_freq;
                        hold_amp  <= evt_amp;
                        state     <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (hold_on) begin
                        if (hit || free) begin
                            tgt   <= hit ? hit_idx : free_idx;
                            F_bus <= hold_freq;
                            A_bus <= hold_amp;
                            state <= LOAD;
                        end else begin
                            tgt       <= steal_ptr;
                            steal_ptr <= (steal_ptr == VW'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
                            state     <= KILL;
                        end
                    end else if (hit) begin
                        tgt   <= hit_idx;
                        state <= OFF;
                    end else begin
                        state <= IDLE;
                    end
                end
                KILL: begin
                    voice_key_on[tgt] <= 1'b0;
                    tag_note[tgt]     <= '0;
                    F_bus             <= hold_freq;
                    A_bus             <= hold_amp;
                    state             <= LOAD;
                end
                LOAD: begin
                    voice_key_on[tgt] <= 1'b1;
                    tag_note[tgt]     <= hold_note;
                    state             <= IDLE;
                end
                OFF: begin
                    voice_key_on[tgt] <= 1'b0;
                    tag_note[tgt]     <= '0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are suppressed while panic is asserted so an aborted load never reaches a voice.
    always_comb begin
        voice_loadF = '0;
        if (state == LOAD && !Reset && !panic) voice_loadF = NUM_VOICES'(1) << tgt;
    end

    assign voice_loadA = voice_loadF;
    assign evt_ready   = (state == IDLE) && !Reset;
    assign steal_pulse = (state == KILL) && !Reset;
    assign miss_pulse  = (state == SEARCH) && !Reset && !hold_on && !hit;

    always_comb begin
        active_count = '0;
        for (int i = 0; i < NUM_VOICES; i++) active_count = active_count + CW'(voice_key_on[i]);
    end

endmodule

// File: tb/tb_nco_voice_allocator.sv
// Self-checking bench for nco_voice_allocator: an event-level model predicts every
// cycle's outputs from the allocation rules and timing table, plus literal spot checks.
module tb_nco_voice_allocator;

    localparam int NV = 4;
    localparam int FW = 24;
    localparam int AW = 16;
    localparam int NW = 7;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          evt_valid = 1'b0;
    logic          evt_ready;
    logic          evt_on = 1'b0;
    logic [NW-1:0] evt_note = '0;
    logic [FW-1:0] evt_freq = '0;
    logic [AW-1:0] evt_amp = '0;
    logic          panic = 1'b0;
    logic [FW-1:0] F_bus;
    logic [AW-1:0] A_bus;
    logic [NV-1:0] voice_loadF;
    logic [NV-1:0] voice_loadA;
    logic [NV-1:0] voice_key_on;
    logic [2:0]    active_count;
    logic          steal_pulse;
    logic          miss_pulse;

    int checks = 0;
    int errors = 0;

    nco_voice_allocator #(.NUM_VOICES(NV), .FW(FW), .AW(AW), .NOTE_W(NW)) dut (
        .Clk(Clk), .Reset(Reset), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_on(evt_on), .evt_note(evt_note), .evt_freq(evt_freq), .evt_amp(evt_amp),
        .panic(panic), .F_bus(F_bus), .A_bus(A_bus), .voice_loadF(voice_loadF),
        .voice_loadA(voice_loadA), .voice_key_on(voice_key_on),
        .active_count(active_count), .steal_pulse(steal_pulse), .miss_pulse(miss_pulse)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic          ready;
        logic [NV-1:0] load;
        logic [NV-1:0] key;
        logic [FW-1:0] f;
        logic [AW-1:0] a;
        logic          steal;
        logic          miss;
    } exp_t;

    // Committed voice state after all in-flight events finish; sched holds per-cycle snapshots.
    logic [NV-1:0] m_key = '0;
    logic [NW-1:0] m_tag [NV];
    logic [FW-1:0] m_f = '0;
    logic [AW-1:0] m_a = '0;
    int            m_ptr = 0;
    bit            model_valid = 0;
    exp_t          sched [$];
    exp_t          e;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic modelAccept(input logic on, input logic [NW-1:0] note,
                               input logic [FW-1:0] freq, input logic [AW-1:0] amp);
        exp_t base;
        exp_t x;
        int   v = -1;
        bit   stealing = 0;
        base.ready = 0; base.load = '0; base.key = m_key; base.f = m_f; base.a = m_a;
        base.steal = 0; base.miss = 0;
        for (int i = 0; i < NV; i++)
            if (v < 0 && m_key[i] && m_tag[i] == note) v = i;
        if (on) begin
            for (int i = 0; i < NV; i++)
                if (v < 0 && !m_key[i]) v = i;
            if (v < 0) begin
                stealing = 1;
                v = m_ptr;
                m_ptr = (m_ptr + 1) % NV;
            end
            sched.push_back(base);
            x = base;
            if (stealing) begin
                x.steal = 1;
                sched.push_back(x);
                x = base;
                x.key[v] = 1'b0;
            end
            x.load = '0;
            x.load[v] = 1'b1;
            x.f = freq;
            x.a = amp;
            sched.push_back(x);
            m_key[v] = 1'b1;
            m_tag[v] = note;
            m_f = freq;
            m_a = amp;
        end else if (v >= 0) begin
            sched.push_back(base);
            sched.push_back(base);
            m_key[v] = 1'b0;
        end else begin
            x = base;
            x.miss = 1;
            sched.push_back(x);
        end
    endtask

    // Compare against the model mid-cycle, then advance the model across the coming edge.
    initial begin
        for (int i = 0; i < NV; i++) m_tag[i] = '0;
        forever begin
            @(negedge Clk);
            if (sched.size() > 0) e = sched[0];
            else begin
                e.ready = 1; e.load = '0; e.key = m_key; e.f = m_f; e.a = m_a;
                e.steal = 0; e.miss = 0;
            end
            if (Reset) begin e.ready = 0; e.load = '0; e.steal = 0; e.miss = 0; end
            if (panic) e.load = '0;
            if (model_valid) begin
                checkOutput("evt_ready", 32'(evt_ready), 32'(e.ready));
                checkOutput("voice_loadF", 32'(voice_loadF), 32'(e.load));
                checkOutput("voice_loadA", 32'(voice_loadA), 32'(e.load));
                checkOutput("voice_key_on", 32'(voice_key_on), 32'(e.key));
                checkOutput("active_count", 32'(active_count), $countones(e.key));
                checkOutput("F_bus", 32'(F_bus), 32'(e.f));
                checkOutput("A_bus", 32'(A_bus), 32'(e.a));
                checkOutput("steal_pulse", 32'(steal_pulse), 32'(e.steal));
                checkOutput("miss_pulse", 32'(miss_pulse), 32'(e.miss));
            end
            if (Reset) begin
                m_key = '0; m_f = '0; m_a = '0; m_ptr = 0;
                for (int i = 0; i < NV; i++) m_tag[i] = '0;
                sched.delete();
                model_valid = 1;
            end else if (panic) begin
                m_key = '0; m_f = e.f; m_a = e.a;
                for (int i = 0; i < NV; i++) m_tag[i] = '0;
                sched.delete();
            end else if (sched.size() > 0) begin
                void'(sched.pop_front());
            end else if (evt_valid) begin
                modelAccept(evt_on, evt_note, evt_freq, evt_amp);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge (start of T+1).
    task automatic applyStimulus(input logic on, input logic [NW-1:0] note,
                                 input logic [FW-1:0] freq, input logic [AW-1:0] amp);
        int waited = 0;
        evt_on = on; evt_note = note; evt_freq = freq; evt_amp = amp; evt_valid = 1'b1;
        @(negedge Clk);
        while (!evt_ready && waited < 50) begin
            @(negedge Clk);
            waited++;
        end
        if (!evt_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: evt_ready stayed 0, expected 1 within 50 cycles");
        end
        @(posedge Clk); #1;
        evt_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int waited = 0;
        @(negedge Clk);
        while (!evt_ready && waited < 50) begin
            @(negedge Clk);
            waited++;
        end
        if (!evt_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: evt_ready stayed 0, expected 1 within 50 cycles");
        end
        @(posedge Clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checkOutput("rst_ready", 32'(evt_ready), 0);
        checkOutput("rst_key_on", 32'(voice_key_on), 0);
        checkOutput("rst_count", 32'(active_count), 0);
        checkOutput("rst_F_bus", 32'(F_bus), 0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("ready_after_rst", 32'(evt_ready), 1);
        @(posedge Clk); #1;

        for (int k = 1; k <= 4; k++)
            applyStimulus(1'b1, NW'(59 + k), FW'(32'h1000 * k), 16'h4000);
        waitIdle();
        @(negedge Clk);
        checkOutput("four_on_count", 32'(active_count), 4);
        checkOutput("four_on_key", 32'(voice_key_on), 32'hF);
        checkOutput("four_on_F", 32'(F_bus), 32'h004000);
        @(posedge Clk); #1;

        applyStimulus(1'b1, 7'd64, 24'h005000, 16'h2000);
        @(negedge Clk);
        checkOutput("steal0_search_pulse", 32'(steal_pulse), 0);
        @(negedge Clk);
        checkOutput("steal0_pulse", 32'(steal_pulse), 1);
        checkOutput("steal0_kill_key", 32'(voice_key_on), 32'hF);
        @(negedge Clk);
        checkOutput("steal0_load_key", 32'(voice_key_on), 32'hE);
        checkOutput("steal0_loadF", 32'(voice_loadF), 32'h1);
        checkOutput("steal0_F", 32'(F_bus), 32'h005000);
        @(negedge Clk);
        checkOutput("steal0_after_key", 32'(voice_key_on), 32'hF);
        checkOutput("steal0_after_ready", 32'(evt_ready), 1);
        @(posedge Clk); #1;

        applyStimulus(1'b1, 7'd65, 24'h006000, 16'h2000);
        repeat (3) @(negedge Clk);
        checkOutput("steal1_loadF", 32'(voice_loadF), 32'h2);
        @(posedge Clk); #1;

        applyStimulus(1'b0, 7'd62, '0, '0);
        repeat (2) @(negedge Clk);
        checkOutput("off62_mid_key", 32'(voice_key_on), 32'hF);
        @(negedge Clk);
        checkOutput("off62_key", 32'(voice_key_on), 32'hB);
        @(posedge Clk); #1;

        applyStimulus(1'b0, 7'd99, '0, '0);
        @(negedge Clk);
        checkOutput("miss_pulse99", 32'(miss_pulse), 1);
        checkOutput("miss_key", 32'(voice_key_on), 32'hB);
        @(negedge Clk);
        checkOutput("miss_ready", 32'(evt_ready), 1);
        @(posedge Clk); #1;

        applyStimulus(1'b1, 7'd61, 24'h007000, 16'h3000);
        waitIdle();
        applyStimulus(1'b1, 7'd61, 24'h007100, 16'h1234);
        @(negedge Clk);
        checkOutput("retrig_search_key", 32'(voice_key_on), 32'hF);
        @(negedge Clk);
        checkOutput("retrig_loadA", 32'(voice_loadA), 32'h4);
        checkOutput("retrig_F", 32'(F_bus), 32'h007100);
        checkOutput("retrig_A", 32'(A_bus), 32'h1234);
        checkOutput("retrig_load_key", 32'(voice_key_on), 32'hF);
        @(negedge Clk);
        checkOutput("retrig_count", 32'(active_count), 4);
        @(posedge Clk); #1;

        applyStimulus(1'b1, 7'd70, 24'h008000, 16'h0800);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        panic = 1'b1;
        @(negedge Clk);
        checkOutput("panic_cycle_loadF", 32'(voice_loadF), 0);
        @(posedge Clk); #1;
        panic = 1'b0;
        @(negedge Clk);
        checkOutput("panic_key", 32'(voice_key_on), 0);
        checkOutput("panic_loadF", 32'(voice_loadF), 0);
        checkOutput("panic_ready", 32'(evt_ready), 1);
        checkOutput("panic_count", 32'(active_count), 0);
        @(posedge Clk); #1;

        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, NW'(71 + k), FW'(32'h100 * (k + 1)), 16'h0100);
        applyStimulus(1'b1, 7'd75, 24'h000900, 16'h0100);
        repeat (3) @(negedge Clk);
        checkOutput("ptr_kept_loadF", 32'(voice_loadF), 32'h8);
        @(posedge Clk); #1;
        waitIdle();

        evt_on = 1'b1; evt_note = 7'd80; evt_freq = 24'h00A000; evt_amp = 16'h0100;
        evt_valid = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b1;
        evt_note = 7'd81; evt_freq = 24'h00B000; evt_amp = 16'h0200;
        @(negedge Clk);
        checkOutput("rst_mid_ready", 32'(evt_ready), 0);
        checkOutput("rst_mid_miss", 32'(miss_pulse), 0);
        @(posedge Clk); #1;
        @(negedge Clk);
        checkOutput("rst_mid_key", 32'(voice_key_on), 0);
        checkOutput("rst_mid_F", 32'(F_bus), 0);
        checkOutput("rst_mid_ready2", 32'(evt_ready), 0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("rst_rel_ready", 32'(evt_ready), 1);
        @(posedge Clk); #1;
        evt_valid = 1'b0;
        repeat (2) @(negedge Clk);
        checkOutput("rst_rel_loadF", 32'(voice_loadF), 32'h1);
        checkOutput("rst_rel_F", 32'(F_bus), 32'h00B000);
        @(posedge Clk); #1;
        waitIdle();

        repeat (3) @(posedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
